// File: rtl/wb_stage_reg.sv
// Writeback stage for the 5-stage MIPS pipeline: MEM/WB register with stall/flush,
// load lane extraction and extension, write-data select and a saturating retire counter.
module wb_stage_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LINK_OFF = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_mem,
  input  logic [31:0]       pc_mem,
  input  logic [DATA_W-1:0] aluout_mem,
  input  logic [DATA_W-1:0] dmout_mem,
  input  logic [DATA_W-1:0] hilo_mem,
  input  logic [1:0]        MemtoReg_mem,
  input  logic [2:0]        ld_type_mem,
  input  logic              RegWrite_mem,
  input  logic [4:0]        a3_mem,
  output logic [DATA_W-1:0] wd_wb,
  output logic [4:0]        a3_wb,
  output logic              we_wb,
  output logic [31:0]       pc_wb,
  output logic              valid_wb,
  output logic              addr_err_wb,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_LINK = 2'b10,
    SEL_HILO = 2'b11
  } wd_sel_e;

  typedef enum logic [2:0] {
    LD_W   = 3'b000,
    LD_BU  = 3'b001,
    LD_B   = 3'b010,
    LD_HU  = 3'b011,
    LD_H   = 3'b100,
    LD_RS5 = 3'b101,
    LD_RS6 = 3'b110,
    LD_RS7 = 3'b111
  } ld_type_e;

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic [DATA_W-1:0] dmout_q, dmout_d;
  logic [DATA_W-1:0] hilo_q, hilo_d;
  wd_sel_e           sel_q, sel_d;
  ld_type_e          ld_type_q, ld_type_d;
  logic              regwrite_q, regwrite_d;
  logic [4:0]        a3_q, a3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    aluout_d   = aluout_q;
    dmout_d    = dmout_q;
    hilo_d     = hilo_q;
    sel_d      = sel_q;
    ld_type_d  = ld_type_q;
    regwrite_d = regwrite_q;
    a3_d       = a3_q;
    if (flush || !stall) begin
      valid_d    = valid_mem;
      pc_d       = pc_mem;
      aluout_d   = aluout_mem;
      dmout_d    = dmout_mem;
      hilo_d     = hilo_mem;
      sel_d      = wd_sel_e'(MemtoReg_mem);
      ld_type_d  = ld_type_e'(ld_type_mem);
      regwrite_d = RegWrite_mem;
      a3_d       = a3_mem;
    end
    // Flush turns the loaded entry into a bubble; only valid/RegWrite matter.
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end
    cnt_d = cnt_q;
    if (valid_q && !stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      aluout_q   <= '0;
      dmout_q    <= '0;
      hilo_q     <= '0;
      sel_q      <= SEL_ALU;
      ld_type_q  <= LD_W;
      regwrite_q <= 1'b0;
      a3_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      aluout_q   <= aluout_d;
      dmout_q    <= dmout_d;
      hilo_q     <= hilo_d;
      sel_q      <= sel_d;
      ld_type_q  <= ld_type_d;
      regwrite_q <= regwrite_d;
      a3_q       <= a3_d;
      cnt_q      <= cnt_d;
    end
  end

  logic [1:0]        off;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] link_data;
  logic              is_half, is_word;

  always_comb begin
    off = aluout_q[1:0];
    case (off)
      2'd0:    byte_v = dmout_q[7:0];
      2'd1:    byte_v = dmout_q[15:8];
      2'd2:    byte_v = dmout_q[23:16];
      default: byte_v = dmout_q[31:24];
    endcase
    half_v = off[1] ? dmout_q[31:16] : dmout_q[15:0];
    is_half = 1'b0;
    is_word = 1'b0;
    case (ld_type_q)
      LD_BU:   load_data = {{(DATA_W-8){1'b0}}, byte_v};
      LD_B:    load_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LD_HU: begin
        load_data = {{(DATA_W-16){1'b0}}, half_v};
        is_half   = 1'b1;
      end
      LD_H: begin
        load_data = {{(DATA_W-16){half_v[15]}}, half_v};
        is_half   = 1'b1;
      end
      default: begin
        load_data = dmout_q;
        is_word   = 1'b1;
      end
    endcase

    link_data       = '0;
    link_data[31:0] = pc_q + 32'(LINK_OFF);

    case (sel_q)
      SEL_ALU:  wd_wb = aluout_q;
      SEL_LOAD: wd_wb = load_data;
      SEL_LINK: wd_wb = link_data;
      default:  wd_wb = hilo_q;
    endcase

    addr_err_wb = valid_q && (sel_q == SEL_LOAD) &&
                  ((is_half && off[0]) || (is_word && off != 2'd0));
    we_wb = valid_q && regwrite_q && (a3_q != 5'd0) && !addr_err_wb;
  end

  assign a3_wb       = a3_q;
  assign pc_wb       = pc_q;
  assign valid_wb    = valid_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed bench for wb_stage_reg: DUT A (LINK_OFF=4, CNT_W=32) and DUT B
// (LINK_OFF=8, CNT_W=4) share one stimulus stream.
module tb_wb_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_mem, RegWrite_mem;
  logic [31:0] pc_mem, aluout_mem, dmout_mem, hilo_mem;
  logic [1:0]  MemtoReg_mem;
  logic [2:0]  ld_type_mem;
  logic [4:0]  a3_mem;

  logic [31:0] wd_a, pc_a, wd_b, pc_b;
  logic [4:0]  a3_a, a3_b;
  logic        we_a, valid_a, aerr_a, we_b, valid_b, aerr_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_reg #(.DATA_W(32), .LINK_OFF(4), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_mem(valid_mem),
    .pc_mem(pc_mem), .aluout_mem(aluout_mem), .dmout_mem(dmout_mem), .hilo_mem(hilo_mem),
    .MemtoReg_mem(MemtoReg_mem), .ld_type_mem(ld_type_mem), .RegWrite_mem(RegWrite_mem),
    .a3_mem(a3_mem), .wd_wb(wd_a), .a3_wb(a3_a), .we_wb(we_a), .pc_wb(pc_a),
    .valid_wb(valid_a), .addr_err_wb(aerr_a), .retired_cnt(cnt_a));

  wb_stage_reg #(.DATA_W(32), .LINK_OFF(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_mem(valid_mem),
    .pc_mem(pc_mem), .aluout_mem(aluout_mem), .dmout_mem(dmout_mem), .hilo_mem(hilo_mem),
    .MemtoReg_mem(MemtoReg_mem), .ld_type_mem(ld_type_mem), .RegWrite_mem(RegWrite_mem),
    .a3_mem(a3_mem), .wd_wb(wd_b), .a3_wb(a3_b), .we_wb(we_b), .pc_wb(pc_b),
    .valid_wb(valid_b), .addr_err_wb(aerr_b), .retired_cnt(cnt_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                     input logic [31:0] dm, input logic [31:0] hl, input logic [1:0] sel,
                     input logic [2:0] ld, input logic rw, input logic [4:0] a3);
    valid_mem = v; pc_mem = pc; aluout_mem = alu; dmout_mem = dm; hilo_mem = hl;
    MemtoReg_mem = sel; ld_type_mem = ld; RegWrite_mem = rw; a3_mem = a3;
  endtask

  localparam logic [31:0] DM = 32'h8096A5F0;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    mem(1'b1, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 3'($urandom), 1'b1, 5'd7);
    tick();
    mem(1'b1, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 3'($urandom), 1'b1, 5'd9);
    tick();
    chk("rst_valid", valid_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_wd", wd_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_a3", a3_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_aerr", aerr_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    reset = 1'b0;

    // Load extraction
    mem(1, 32'h100, 32'h1001, DM, 0, 2'b01, 3'b010, 1, 5'd8); tick();
    chk("lb_wd", wd_a, 32'hFFFFFFA5); chk("lb_we", we_a, 1);
    chk("lb_a3", a3_a, 8); chk("lb_pc", pc_a, 32'h100); chk("lb_cnt", cnt_a, 0);
    mem(1, 32'h104, 32'h1001, DM, 0, 2'b01, 3'b001, 1, 5'd8); tick();
    chk("lbu_wd", wd_a, 32'h000000A5); chk("lbu_we", we_a, 1); chk("lbu_cnt", cnt_a, 1);
    mem(1, 32'h108, 32'h1002, DM, 0, 2'b01, 3'b100, 1, 5'd8); tick();
    chk("lh_wd", wd_a, 32'hFFFF8096); chk("lh_we", we_a, 1);
    mem(1, 32'h10C, 32'h1002, DM, 0, 2'b01, 3'b011, 1, 5'd8); tick();
    chk("lhu_wd", wd_a, 32'h00008096); chk("lhu_we", we_a, 1);
    mem(1, 32'h110, 32'h1000, DM, 0, 2'b01, 3'b000, 1, 5'd8); tick();
    chk("lw_wd", wd_a, 32'h8096A5F0); chk("lw_we", we_a, 1);
    chk("lw_aerr", aerr_a, 0); chk("lw_cnt", cnt_a, 4);

    // Misalignment
    mem(1, 32'h114, 32'h1002, DM, 0, 2'b01, 3'b000, 1, 5'd8); tick();
    chk("lw_mis_aerr", aerr_a, 1); chk("lw_mis_we", we_a, 0); chk("lw_mis_cnt", cnt_a, 5);
    mem(1, 32'h118, 32'h1003, DM, 0, 2'b01, 3'b100, 1, 5'd8); tick();
    chk("lh_mis_aerr", aerr_a, 1); chk("lh_mis_we", we_a, 0); chk("lh_mis_cnt", cnt_a, 6);
    mem(1, 32'h11C, 32'h1003, DM, 0, 2'b01, 3'b010, 1, 5'd8); tick();
    chk("lb3_wd", wd_a, 32'hFFFFFF80); chk("lb3_aerr", aerr_a, 0);
    chk("lb3_we", we_a, 1); chk("lb3_cnt", cnt_a, 7);

    // Link, HI/LO, $0
    mem(1, 32'h3000, 32'h1234, DM, 0, 2'b10, 3'b000, 1, 5'd31); tick();
    chk("jal_wd_a", wd_a, 32'h00003004); chk("jal_wd_b", wd_b, 32'h00003008);
    chk("jal_we", we_a, 1); chk("jal_a3", a3_a, 31);
    mem(1, 32'h3004, 32'h1234, DM, 32'h12345678, 2'b11, 3'b000, 1, 5'd2); tick();
    chk("hilo_wd", wd_a, 32'h12345678); chk("hilo_cnt", cnt_a, 9);
    mem(1, 32'h3008, 32'hDEADBEEF, DM, 0, 2'b00, 3'b000, 1, 5'd0); tick();
    chk("zero_we", we_a, 0); chk("zero_wd", wd_a, 32'hDEADBEEF);

    // Stall / flush
    mem(1, 32'h400, 32'hCAFE0001, DM, 0, 2'b00, 3'b000, 1, 5'd5); tick();
    chk("pre_stall_cnt", cnt_a, 11);
    stall = 1'b1;
    mem(1, 32'h500, 32'h11111111, DM, 0, 2'b00, 3'b000, 1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_wd", wd_a, 32'hCAFE0001); chk("stall_a3", a3_a, 5);
      chk("stall_pc", pc_a, 32'h400); chk("stall_we", we_a, 1);
      chk("stall_cnt", cnt_a, 11);
    end
    stall = 1'b0; tick();
    chk("unstall_wd", wd_a, 32'h11111111); chk("unstall_a3", a3_a, 9);
    chk("unstall_cnt", cnt_a, 12);
    stall = 1'b1; flush = 1'b1; tick();
    chk("sf_valid", valid_a, 0); chk("sf_we", we_a, 0); chk("sf_cnt", cnt_a, 12);
    stall = 1'b0; flush = 1'b0;
    mem(1, 32'h600, 32'h55, DM, 0, 2'b00, 3'b000, 1, 5'd4); tick();
    chk("post_sf_valid", valid_a, 1); chk("post_sf_wd", wd_a, 32'h55); chk("post_sf_cnt", cnt_a, 12);
    flush = 1'b1; tick();
    chk("fl_valid", valid_a, 0); chk("fl_we", we_a, 0); chk("fl_cnt", cnt_a, 13);
    chk("fl_cnt_b", cnt_b, 13);
    flush = 1'b0; tick();
    chk("refill_valid", valid_a, 1);
    reset = 1'b1; flush = 1'b1; stall = 1'b1; tick();
    chk("rf_valid", valid_a, 0); chk("rf_we", we_a, 0); chk("rf_wd", wd_a, 0);
    chk("rf_a3", a3_a, 0); chk("rf_pc", pc_a, 0); chk("rf_cnt", cnt_a, 0);
    chk("rf_cnt_b", cnt_b, 0);
    reset = 1'b0; flush = 1'b0; stall = 1'b0;

    // Counter saturation on the 4-bit counter
    for (int i = 1; i <= 20; i++) begin
      mem(1, 32'h700 + 32'(4 * i), 32'(i), DM, 0, 2'b00, 3'b000, 1, 5'd3);
      tick();
      if (i == 16) begin
        chk("sat16_a", cnt_a, 15); chk("sat16_b", cnt_b, 15);
      end
      if (i == 17) begin
        chk("sat17_a", cnt_a, 16); chk("sat17_b", cnt_b, 15);
      end
    end
    chk("sat20_a", cnt_a, 19);
    chk("sat20_b", cnt_b, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
